// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT   = 16;

  // Bundle of every pipeline control the unit drives, in output order.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / freeze / flush sequencing for the 5-stage pipeline, with a
// data-memory watchdog and saturating performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            freeze;
  logic            lu;
  logic            act_branch;
  logic            act_lu;
  ctrl_t           ctrl;

  assign freeze = dmem_req_MEM & ~dmem_ready & ~mem_timeout;
  assign lu     = mem_read_EX & (rd_EX != REG_ZERO) &
                  ((rs1_ID == rd_EX) | (uses_rs2_ID & (rs2_ID == rd_EX)));

  // Priority: freeze > branch > load-use; a taken branch discards the ID
  // instruction, so its load-use hazard is moot.
  assign act_branch = ~freeze & branch_taken_EX;
  assign act_lu     = ~freeze & ~branch_taken_EX & lu;

  // NOTE: every always_comb output gets a default first so no latch is
  // inferred on paths that skip an assignment.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (act_branch) begin
      ctrl = CTRL_BRANCH;
    end else if (act_lu) begin
      ctrl = CTRL_LU;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign id_ex_write   = ctrl.id_ex_write;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  // wait_cnt holds the number of frozen cycles already elapsed in this wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
              mem_timeout <= 1'b1;
              state       <= RUN;
              wait_cnt    <= '0;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze | act_lu),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act_branch),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scenario tests plus randomized checking of hazard_control_unit against a
// cycle-level behavioural model.
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int T    = 4;
  localparam int W    = 3;
  localparam int MAXC = (1 << W) - 1;

  // Expected control vectors {pc, if_id_w, id_ex_w, ex_mem_w, if_id_fl, id_ex_fl, bubble}
  localparam logic [6:0] P_RESET  = 7'b0000111;
  localparam logic [6:0] P_FREEZE = 7'b0000001;
  localparam logic [6:0] P_BRANCH = 7'b1111110;
  localparam logic [6:0] P_LU     = 7'b0011010;
  localparam logic [6:0] P_NORM   = 7'b1111000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   rs1 = '0, rs2 = '0, rd = '0;
  logic         u2 = 1'b0, mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic         pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic         if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
  logic [W-1:0] stall_count, flush_count;
  logic [6:0]   ctrl;

  int total = 0;
  int bad   = 0;

  // Model state: consecutive frozen cycles, sticky flag, unbounded counts.
  int m_stall, m_flush, m_consec;
  bit m_to;

  always #5 clk = ~clk;

  hazard_control_unit #(.TIMEOUT(T), .CNT_W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_ID          (rs1),
    .rs2_ID          (rs2),
    .uses_rs2_ID     (u2),
    .rd_EX           (rd),
    .mem_read_EX     (mr),
    .branch_taken_EX (br),
    .dmem_req_MEM    (req),
    .dmem_ready      (rdy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, mem_wb_bubble};

  function automatic bit model_hazard();
    return mr && (rd != 5'd0) && ((rs1 == rd) || (u2 && (rs2 == rd)));
  endfunction

  function automatic logic [6:0] model_ctrl();
    bit fr;
    fr = req && !rdy && !m_to;
    if (!rst_n)            return P_RESET;
    if (fr)                return P_FREEZE;
    if (br)                return P_BRANCH;
    if (model_hazard())    return P_LU;
    return P_NORM;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_consec = 0; m_to = 0;
  endtask

  task automatic model_advance();
    bit fr;
    fr = req && !rdy && !m_to;
    if (fr) begin
      m_consec++;
      if (m_consec == T) begin
        m_to = 1;
        m_consec = 0;
      end
    end else begin
      m_consec = 0;
    end
    if (fr || (!br && model_hazard())) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
    if (!fr && br)                     m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
  endtask

  task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic u,
                        input logic [4:0] d, input logic m, input logic bb,
                        input logic q, input logic r);
    rs1 = a; rs2 = b; u2 = u; rd = d; mr = m; br = bb; req = q; rdy = r;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    model_reset();
    #12;
    total++; if (ctrl !== P_RESET) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, P_RESET); end
    total++; if (stall_count !== '0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
    total++; if (flush_count !== '0) begin bad++; $display("FAIL reset_flush got=%0d want=0", flush_count); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", mem_timeout); end
    total++; if (dut.state !== RUN) begin bad++; $display("FAIL reset_state got=%b want=RUN", dut.state); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (ctrl !== P_NORM) begin bad++; $display("FAIL post_reset_ctrl got=%b want=%b", ctrl, P_NORM); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (ctrl !== P_LU) begin bad++; $display("FAIL lu_ctrl got=%b want=%b", ctrl, P_LU); end
    tick();
    total++; if (stall_count !== 3'd1) begin bad++; $display("FAIL lu_stall got=%0d want=1", stall_count); end
    set_in(5, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    total++; if (ctrl !== P_NORM) begin bad++; $display("FAIL lu_next_ctrl got=%b want=%b", ctrl, P_NORM); end
    tick();
    total++; if (stall_count !== 3'd1) begin bad++; $display("FAIL lu_next_stall got=%0d want=1", stall_count); end
  endtask

  task automatic test_rs2_gating();
    do_reset();
    set_in(3, 5, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (ctrl !== P_NORM) begin bad++; $display("FAIL rs2_unused got=%b want=%b", ctrl, P_NORM); end
    tick();
    set_in(0, 0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (ctrl !== P_NORM) begin bad++; $display("FAIL rd_zero got=%b want=%b", ctrl, P_NORM); end
    tick();
    set_in(3, 5, 1, 5, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (ctrl !== P_LU) begin bad++; $display("FAIL rs2_used got=%b want=%b", ctrl, P_LU); end
    tick();
    total++; if (stall_count !== 3'd1) begin bad++; $display("FAIL rs2_stall got=%0d want=1", stall_count); end
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_in(5, 0, 0, 5, 1, 1, 0, 0);
    @(negedge clk);
    total++; if (ctrl !== P_BRANCH) begin bad++; $display("FAIL br_lu_ctrl got=%b want=%b", ctrl, P_BRANCH); end
    tick();
    total++; if (flush_count !== 3'd1) begin bad++; $display("FAIL br_lu_flush got=%0d want=1", flush_count); end
    total++; if (stall_count !== 3'd0) begin bad++; $display("FAIL br_lu_stall got=%0d want=0", stall_count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      total++; if (ctrl !== P_FREEZE) begin bad++; $display("FAIL wait_ctrl[%0d] got=%b want=%b", i, ctrl, P_FREEZE); end
      tick();
      total++; if (dut.state !== MEM_WAIT) begin bad++; $display("FAIL wait_state[%0d] got=%b want=MEM_WAIT", i, dut.state); end
    end
    total++; if (stall_count !== 3'd3) begin bad++; $display("FAIL wait_stall got=%0d want=3", stall_count); end
    total++; if (flush_count !== 3'd0) begin bad++; $display("FAIL wait_flush_held got=%0d want=0", flush_count); end
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge clk);
    total++; if (ctrl !== P_BRANCH) begin bad++; $display("FAIL release_ctrl got=%b want=%b", ctrl, P_BRANCH); end
    tick();
    total++; if (flush_count !== 3'd1) begin bad++; $display("FAIL release_flush got=%0d want=1", flush_count); end
    total++; if (stall_count !== 3'd3) begin bad++; $display("FAIL release_stall got=%0d want=3", stall_count); end
    total++; if (dut.state !== RUN) begin bad++; $display("FAIL release_state got=%b want=RUN", dut.state); end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < T; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      total++; if (ctrl !== P_FREEZE) begin bad++; $display("FAIL wd_ctrl[%0d] got=%b want=%b", i, ctrl, P_FREEZE); end
      total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wd_early[%0d] got=%b want=0", i, mem_timeout); end
      tick();
    end
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL wd_fire got=%b want=1", mem_timeout); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctrl !== P_NORM) begin bad++; $display("FAIL wd_unhung[%0d] got=%b want=%b", i, ctrl, P_NORM); end
      total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky[%0d] got=%b want=1", i, mem_timeout); end
      tick();
    end
    total++; if (stall_count !== 3'(T)) begin bad++; $display("FAIL wd_stall got=%0d want=%0d", stall_count, T); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wd_async_clear got=%b want=0", mem_timeout); end
    total++; if (stall_count !== '0) begin bad++; $display("FAIL wd_async_stall got=%0d want=0", stall_count); end
    total++; if (ctrl !== P_RESET) begin bad++; $display("FAIL wd_async_ctrl got=%b want=%b", ctrl, P_RESET); end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(7, 0, 0, 7, 1, 0, 0, 0);
      tick();
      total++;
      if (stall_count !== 3'((i + 1 < MAXC) ? i + 1 : MAXC)) begin
        bad++; $display("FAIL sat_stall[%0d] got=%0d want=%0d", i, stall_count, (i + 1 < MAXC) ? i + 1 : MAXC);
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    total++; if (stall_count !== 3'd7) begin bad++; $display("FAIL sat_final got=%0d want=7", stall_count); end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int n = 0; n < 200; n++) begin
        set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        @(negedge clk);
        exp = model_ctrl();
        total++; if (ctrl !== exp) begin bad++; $display("FAIL rnd_ctrl[%0d] got=%b want=%b", n, ctrl, exp); end
        tick();
        total++; if (stall_count !== W'(m_stall)) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d want=%0d", n, stall_count, m_stall); end
        total++; if (flush_count !== W'(m_flush)) begin bad++; $display("FAIL rnd_flush[%0d] got=%0d want=%0d", n, flush_count, m_flush); end
        total++; if (mem_timeout !== m_to) begin bad++; $display("FAIL rnd_timeout[%0d] got=%b want=%b", n, mem_timeout, m_to); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rs2_gating();
    test_branch_lu();
    test_mem_wait();
    test_watchdog();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Generates the stall, freeze and flush controls that the forwarding unit cannot cover by itself.
- Resolves load-use hazards with a 1-cycle bubble, branch-taken redirects with IF/ID and ID/EX flushes, and multi-cycle data-memory waits with a full freeze plus watchdog.
- Sits beside the forwarding unit in the top-level core. Drives the pipeline-register write enables and flush inputs, and the PC write enable.

Parameters:
- TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before the watchdog fires (must be ≥2).
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_ID  input  5  rs1 of the instruction in ID.
- rs2_ID  input  5  rs2 of the instruction in ID.
- uses_rs2_ID  input  1  1 if the ID instruction reads rs2 (R/S/B types).
- rd_EX  input  5  destination register of the instruction in EX.
- mem_read_EX  input  1  1 if the EX instruction is a load.
- branch_taken_EX  input  1  branch/jump in EX resolved taken.
- dmem_req_MEM  input  1  MEM-stage instruction accesses data memory.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC register enable.
- if_id_write  output  1  IF/ID register enable.
- id_ex_write  output  1  ID/EX register enable.
- ex_mem_write  output  1  EX/MEM register enable.
- if_id_flush  output  1  clear IF/ID to NOP.
- id_ex_flush  output  1  clear ID/EX to NOP (bubble).
- mem_wb_bubble  output  1  insert NOP into MEM/WB.
- mem_timeout  output  1  sticky watchdog error flag.
- stall_count  output  CNT_W  saturating count of load-use plus freeze cycles.
- flush_count  output  CNT_W  saturating count of branch flush events.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to RUN; wait_cnt=0; mem_timeout=0; both counters 0.
  - While reset is held, all write enables are 0 and if_id_flush, id_ex_flush and mem_wb_bubble are 1.
- Definitions:
  - freeze = dmem_req_MEM & ~dmem_ready & ~mem_timeout.
  - lu = mem_read_EX & (rd_EX≠0) & ((rs1_ID==rd_EX) | (uses_rs2_ID & rs2_ID==rd_EX)).
- Control outputs are combinational from state and inputs, zero latency. Priority order: freeze > branch > load-use > normal.
  - freeze: all four write enables 0, mem_wb_bubble=1, no flushes. The branch stays held in EX and is acted on in the first unfrozen cycle.
  - branch_taken_EX (not frozen): all enables 1, if_id_flush=1, id_ex_flush=1. The load-use check is suppressed because the ID instruction is discarded.
  - lu (no freeze, no branch): pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1. Exactly 1 bubble; next cycle the load is in MEM and lu deasserts.
  - normal: all enables 1, all flushes 0.
- FSM states are RUN and MEM_WAIT.
  - RUN→MEM_WAIT when freeze=1; wait_cnt is loaded with 1.
  - MEM_WAIT→RUN on dmem_ready=1. The pipeline advances that same cycle; wait_cnt clears.
  - In MEM_WAIT with freeze=1, wait_cnt increments.
  - When wait_cnt reaches TIMEOUT with ready still 0: mem_timeout sets (sticky until reset) and the state goes to RUN.
  - Once mem_timeout=1, freeze is masked so the pipeline is never hung; software or the bench observes the flag.
- Counters (registered):
  - stall_count +1 on each cycle where freeze or lu is the active case.
  - flush_count +1 on each cycle where the branch case is active.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Simultaneous events:
  - dmem_ready arriving in the same cycle as a new request in RUN means no freeze, so there is no state change.
  - A branch and lu together resolve as branch only.
  - rd_EX=0 never stalls.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; the counters and the flag clear.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - constant REG_ZERO=5'd0;
  - the default values of TIMEOUT and CNT_W.
- One natural sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice for stall_count and flush_count.

Test Plan:
- Load-use: lw x5 in EX (mem_read_EX=1, rd_EX=5), rs1_ID=5 → exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1; the next cycle is normal.
- rs2 gating: rs2_ID=5, uses_rs2_ID=0, rd_EX=5, mem_read_EX=1 → no stall. Repeat with rd_EX=0 and rs1_ID=0 → no stall.
- Branch plus load-use in the same cycle: branch_taken_EX=1 and lu=1 → if_id_flush=id_ex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- Memory wait: dmem_req_MEM=1 with ready low for 3 cycles, then high →
  - 3 cycles with all enables 0 and mem_wb_bubble=1, then release on the ready cycle;
  - stall_count=3; state back in RUN.
  - A branch held in EX during the wait flushes only on the release cycle.
- Watchdog: TIMEOUT=4 with ready held low → mem_timeout=1 after 4 wait cycles, enables return to 1 and the flag stays 1; asserting rst_n=0 clears it asynchronously.
- Saturation: CNT_W=3, 10 load-use events → stall_count stops at 7.
